// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter. Picks one finished FU result per cycle
// into a registered output stage that drives PRF writes, ROB completion and
// issue-queue wakeup. The output stage holds its result while wb_stall is high.
module wb_arbiter #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   localparam int IDX_W       = $clog2(FU_COUNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [FU_COUNT-1:0]     src_valid,
   output logic [FU_COUNT-1:0]     src_ready,
   input  logic [INST_ID_BITS-1:0] src_inst_id [FU_COUNT],
   input  logic [MAX_OPERANDS-1:0] src_wen     [FU_COUNT],
   input  logic [PRN_BITS-1:0]     src_prn     [FU_COUNT][MAX_OPERANDS],
   input  logic [63:0]             src_data    [FU_COUNT][MAX_OPERANDS],
   input  logic                    wb_stall,
   output logic [MAX_OPERANDS-1:0] prf_write_enable,
   output logic [PRN_BITS-1:0]     prf_write_prn [MAX_OPERANDS],
   output logic [63:0]             prf_write     [MAX_OPERANDS],
   output logic [MAX_OPERANDS-1:0] set_prn_ready,
   output logic [PRN_BITS-1:0]     set_prn       [MAX_OPERANDS],
   output logic                    wb_valid,
   output logic [INST_ID_BITS-1:0] wb_inst_id,
   output logic [IDX_W-1:0]        wb_src
);

   logic [IDX_W-1:0]        rr_ptr_r;
   logic                    wb_valid_r;
   logic [INST_ID_BITS-1:0] out_inst_id_r;
   logic [IDX_W-1:0]        out_src_r;
   logic [MAX_OPERANDS-1:0] out_wen_r;
   logic [PRN_BITS-1:0]     out_prn_r  [MAX_OPERANDS];
   logic [63:0]             out_data_r [MAX_OPERANDS];

   logic                    accept_s;
   logic                    found_s;
   logic                    grant_s;
   logic [IDX_W-1:0]        winner_s;
   logic [IDX_W:0]          scan_idx_s;
   logic [IDX_W-1:0]        next_ptr_s;

   // Output stage can take a new result when empty or not stalled; never during reset.
   assign accept_s = !rst && (!wb_valid_r || !wb_stall);
   assign grant_s  = accept_s && found_s;

   // Round-robin scan starting at rr_ptr, wrapping modulo FU_COUNT; first valid FU wins.
   always_comb begin
      found_s    = 1'b0;
      winner_s   = '0;
      scan_idx_s = '0;
      for (int k = 0; k < FU_COUNT; k++) begin
         scan_idx_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         if (scan_idx_s >= (IDX_W+1)'(FU_COUNT)) begin
            scan_idx_s = scan_idx_s - (IDX_W+1)'(FU_COUNT);
         end else begin
            scan_idx_s = scan_idx_s;
         end
         if (!found_s && src_valid[scan_idx_s[IDX_W-1:0]]) begin
            found_s  = 1'b1;
            winner_s = scan_idx_s[IDX_W-1:0];
         end else begin
            found_s  = found_s;
            winner_s = winner_s;
         end
      end
   end

   // One-hot ready to the winning FU only; all zero when the stage cannot accept.
   always_comb begin
      src_ready = '0;
      if (grant_s) begin
         src_ready[winner_s] = 1'b1;
      end else begin
         src_ready = '0;
      end
   end

   // Pointer moves to the FU just after the winner so it gets lowest priority next.
   always_comb begin
      next_ptr_s = '0;
      if (winner_s == IDX_W'(FU_COUNT - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = winner_s + IDX_W'(1);
      end
   end

   // Output stage and round-robin pointer: load on grant, drain when idle, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r      <= '0;
         wb_valid_r    <= 1'b0;
         out_inst_id_r <= '0;
         out_src_r     <= '0;
         out_wen_r     <= '0;
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            out_prn_r[k]  <= '0;
            out_data_r[k] <= '0;
         end
      end else if (grant_s) begin
         rr_ptr_r      <= next_ptr_s;
         wb_valid_r    <= 1'b1;
         out_inst_id_r <= src_inst_id[winner_s];
         out_src_r     <= winner_s;
         out_wen_r     <= src_wen[winner_s];
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            out_prn_r[k]  <= src_prn[winner_s][k];
            out_data_r[k] <= src_data[winner_s][k];
         end
      end else if (accept_s) begin
         // Nothing to take: the slot empties, payload is left stale.
         wb_valid_r <= 1'b0;
      end else begin
         wb_valid_r <= wb_valid_r;
      end
   end

   assign wb_valid         = wb_valid_r;
   assign wb_inst_id       = out_inst_id_r;
   assign wb_src           = out_src_r;
   assign prf_write_enable = out_wen_r & {MAX_OPERANDS{wb_valid_r}};
   assign set_prn_ready    = out_wen_r & {MAX_OPERANDS{wb_valid_r}};
   assign prf_write_prn    = out_prn_r;
   assign set_prn          = out_prn_r;
   assign prf_write        = out_data_r;

endmodule
